// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, opcode
// constants and the default reset PC.
package instr_fetch_unit_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump, taken BEQ, or sequential PC + 4.
module next_pc_calc #(
   parameter int W = 32
) (
   input  logic [W-1:0] pc,
   input  logic [W-1:0] instr,
   input  logic         jump,
   input  logic         branch,
   input  logic         zero,
   output logic [W-1:0] pc_plus4,
   output logic [W-1:0] next_pc
);

   logic [W-1:0] branch_off;
   logic [W-1:0] jump_target;

   assign pc_plus4    = pc + {{(W-3){1'b0}}, 3'd4};
   assign branch_off  = {{(W-18){instr[15]}}, instr[15:0], 2'b00};
   assign jump_target = {pc_plus4[W-1:28], instr[25:0], 2'b00};

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_pc = pc_plus4;
      if (jump)
         next_pc = jump_target;
      else if (branch && zero)
         next_pc = pc_plus4 + branch_off;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Two-state fetch/issue unit: requests one instruction word, presents it until
// it retires, then advances the PC through next_pc_calc.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Jump,
   input  logic                  Branch,
   input  logic                  Zero,
   input  logic                  Stall,
   output logic                  Imem_Req,
   output logic [DATA_WIDTH-1:0] Imem_Addr,
   input  logic [DATA_WIDTH-1:0] Imem_Rdata,
   input  logic                  Imem_Valid,
   output logic [DATA_WIDTH-1:0] Instr,
   output logic                  Instr_Valid,
   output logic [5:0]            Op_Code,
   output logic [DATA_WIDTH-1:0] PC,
   output logic [DATA_WIDTH-1:0] PC_Plus4,
   output logic [31:0]           Retire_Count
);

   state_t                state;
   logic [DATA_WIDTH-1:0] next_pc;

   next_pc_calc #(.W(DATA_WIDTH)) u_next_pc (
      .pc       (PC),
      .instr    (Instr),
      .jump     (Jump),
      .branch   (Branch),
      .zero     (Zero),
      .pc_plus4 (PC_Plus4),
      .next_pc  (next_pc)
   );

   // Gating with RST keeps the request low during reset and lets the first
   // request appear in the very first cycle after RST drops.
   assign Imem_Req  = (state == FETCH) && !RST;
   assign Imem_Addr = PC;
   assign Op_Code   = Instr[DATA_WIDTH-1 -: 6];

   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= FETCH;
         PC           <= RESET_PC;
         Instr        <= '0;
         Instr_Valid  <= 1'b0;
         Retire_Count <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (Imem_Valid) begin
                  Instr       <= Imem_Rdata;
                  Instr_Valid <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (!Stall) begin
                  PC           <= next_pc;
                  Instr_Valid  <= 1'b0;
                  Retire_Count <= Retire_Count + 32'd1;
                  state        <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, fetch latency, wait states,
// branch/jump targets, stall hold, reset during issue and PC wrap.
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        Jump = 1'b0, Branch = 1'b0, Zero = 1'b0, Stall = 1'b0;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic [31:0] Imem_Rdata = 32'h0;
   logic        Imem_Valid = 1'b0;
   logic [31:0] Instr;
   logic        Instr_Valid;
   logic [5:0]  Op_Code;
   logic [31:0] PC, PC_Plus4, Retire_Count;

   int total = 0;
   int bad   = 0;

   instr_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .Jump         (Jump),
      .Branch       (Branch),
      .Zero         (Zero),
      .Stall        (Stall),
      .Imem_Req     (Imem_Req),
      .Imem_Addr    (Imem_Addr),
      .Imem_Rdata   (Imem_Rdata),
      .Imem_Valid   (Imem_Valid),
      .Instr        (Instr),
      .Instr_Valid  (Instr_Valid),
      .Op_Code      (Op_Code),
      .PC           (PC),
      .PC_Plus4     (PC_Plus4),
      .Retire_Count (Retire_Count)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are observed on the falling edge.
   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] word);
      Imem_Valid = 1'b1;
      Imem_Rdata = word;
      tick();
      Imem_Valid = 1'b0;
      Imem_Rdata = 32'h0;
   endtask

   task automatic do_retire(input logic j, input logic b, input logic z);
      Jump = j; Branch = b; Zero = z; Stall = 1'b0;
      tick();
      Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      tick();
      tick();
      total++; if (Imem_Req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", Imem_Req); end
      total++; if (Instr_Valid !== 1'b0) begin bad++; $display("FAIL rst_ivalid: got %b want 0", Instr_Valid); end
      total++; if (PC !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 00000000", PC); end
      total++; if (Instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 00000000", Instr); end
      total++; if (Retire_Count !== 32'h0) begin bad++; $display("FAIL rst_count: got %0d want 0", Retire_Count); end
      RST = 1'b0;
      #1;
      total++; if (Imem_Req !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", Imem_Req); end
      total++; if (Imem_Addr !== 32'h0) begin bad++; $display("FAIL first_addr: got %h want 00000000", Imem_Addr); end
   endtask

   task automatic test_zero_wait();
      do_fetch(32'h2008_0005);
      total++; if (Instr_Valid !== 1'b1) begin bad++; $display("FAIL zw_ivalid: got %b want 1", Instr_Valid); end
      total++; if (Op_Code !== OP_ADDI) begin bad++; $display("FAIL zw_opcode: got %b want 001000", Op_Code); end
      total++; if (PC !== 32'h0) begin bad++; $display("FAIL zw_pc: got %h want 00000000", PC); end
      total++; if (Instr !== 32'h2008_0005) begin bad++; $display("FAIL zw_instr: got %h want 20080005", Instr); end
      total++; if (Imem_Req !== 1'b0) begin bad++; $display("FAIL zw_req_issue: got %b want 0", Imem_Req); end
      do_retire(1'b0, 1'b0, 1'b0);
      total++; if (Imem_Req !== 1'b1) begin bad++; $display("FAIL zw_req_next: got %b want 1", Imem_Req); end
      total++; if (Imem_Addr !== 32'h4) begin bad++; $display("FAIL zw_addr_next: got %h want 00000004", Imem_Addr); end
      total++; if (Instr_Valid !== 1'b0) begin bad++; $display("FAIL zw_ivalid_retired: got %b want 0", Instr_Valid); end
      total++; if (Retire_Count !== 32'd1) begin bad++; $display("FAIL zw_count: got %0d want 1", Retire_Count); end
   endtask

   task automatic test_delayed_valid();
      for (int i = 0; i < 3; i++) begin
         total++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h4) begin bad++; $display("FAIL dly_hold%0d: got req=%b addr=%h want req=1 addr=00000004", i, Imem_Req, Imem_Addr); end
         total++; if (Instr_Valid !== 1'b0) begin bad++; $display("FAIL dly_ivalid%0d: got %b want 0", i, Instr_Valid); end
         tick();
      end
      total++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h4) begin bad++; $display("FAIL dly_hold3: got req=%b addr=%h want req=1 addr=00000004", Imem_Req, Imem_Addr); end
      do_fetch(32'h8C22_0010);
      total++; if (Instr_Valid !== 1'b1) begin bad++; $display("FAIL dly_ivalid_rise: got %b want 1", Instr_Valid); end
      total++; if (Op_Code !== OP_LW) begin bad++; $display("FAIL dly_opcode: got %b want 100011", Op_Code); end
      // A stray Imem_Valid while issuing must not overwrite Instr.
      Stall = 1'b1;
      Imem_Valid = 1'b1;
      Imem_Rdata = 32'hDEAD_BEEF;
      tick();
      Imem_Valid = 1'b0;
      total++; if (Instr !== 32'h8C22_0010) begin bad++; $display("FAIL dly_ignore_valid: got %h want 8c220010", Instr); end
      do_retire(1'b0, 1'b0, 1'b0);
      total++; if (Imem_Addr !== 32'h8 || Retire_Count !== 32'd2) begin bad++; $display("FAIL dly_retire: got addr=%h cnt=%0d want addr=00000008 cnt=2", Imem_Addr, Retire_Count); end
   endtask

   task automatic test_branch();
      do_fetch(32'h1000_FFFE);
      total++; if (PC_Plus4 !== 32'hC) begin bad++; $display("FAIL br_pc_plus4: got %h want 0000000c", PC_Plus4); end
      total++; if (Op_Code !== OP_BEQ) begin bad++; $display("FAIL br_opcode: got %b want 000100", Op_Code); end
      do_retire(1'b0, 1'b1, 1'b1);
      total++; if (Imem_Addr !== 32'h4) begin bad++; $display("FAIL br_taken: got %h want 00000004", Imem_Addr); end
      do_fetch(32'h0000_0000);
      do_retire(1'b0, 1'b0, 1'b0);
      total++; if (Imem_Addr !== 32'h8) begin bad++; $display("FAIL br_seq: got %h want 00000008", Imem_Addr); end
      do_fetch(32'h1000_FFFE);
      do_retire(1'b0, 1'b1, 1'b0);
      total++; if (Imem_Addr !== 32'hC) begin bad++; $display("FAIL br_not_taken: got %h want 0000000c", Imem_Addr); end
      total++; if (Retire_Count !== 32'd5) begin bad++; $display("FAIL br_count: got %0d want 5", Retire_Count); end
   endtask

   task automatic test_stall();
      do_fetch(32'h0000_0020);
      Stall = 1'b1;
      // Jump/Branch/Zero toggled while stalled must not affect the retire.
      Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (Instr !== 32'h0000_0020 || PC !== 32'hC) begin bad++; $display("FAIL stall_hold%0d: got instr=%h pc=%h want instr=00000020 pc=0000000c", i, Instr, PC); end
         total++; if (Retire_Count !== 32'd5 || Instr_Valid !== 1'b1) begin bad++; $display("FAIL stall_cnt%0d: got cnt=%0d iv=%b want cnt=5 iv=1", i, Retire_Count, Instr_Valid); end
         total++; if (Imem_Req !== 1'b0) begin bad++; $display("FAIL stall_req%0d: got %b want 0", i, Imem_Req); end
      end
      do_retire(1'b0, 1'b0, 1'b0);
      total++; if (Retire_Count !== 32'd6) begin bad++; $display("FAIL stall_release_cnt: got %0d want 6", Retire_Count); end
      total++; if (Imem_Addr !== 32'h10) begin bad++; $display("FAIL stall_release_addr: got %h want 00000010", Imem_Addr); end
   endtask

   task automatic test_jump();
      do_fetch(32'h0BFF_FFFF);
      total++; if (Op_Code !== OP_J) begin bad++; $display("FAIL j_opcode: got %b want 000010", Op_Code); end
      do_retire(1'b1, 1'b0, 1'b0);
      total++; if (Imem_Addr !== 32'h0FFF_FFFC) begin bad++; $display("FAIL j_low: got %h want 0ffffffc", Imem_Addr); end
      do_fetch(32'h0800_0000);
      total++; if (PC_Plus4 !== 32'h1000_0000) begin bad++; $display("FAIL j_pc_plus4: got %h want 10000000", PC_Plus4); end
      do_retire(1'b1, 1'b0, 1'b0);
      total++; if (Imem_Addr !== 32'h1000_0000) begin bad++; $display("FAIL j_region: got %h want 10000000", Imem_Addr); end
      do_fetch(32'h0800_0040);
      do_retire(1'b1, 1'b1, 1'b1);
      total++; if (Imem_Addr !== 32'h1000_0100) begin bad++; $display("FAIL j_priority: got %h want 10000100", Imem_Addr); end
      total++; if (Retire_Count !== 32'd9) begin bad++; $display("FAIL j_count: got %0d want 9", Retire_Count); end
   endtask

   task automatic test_reset_in_issue();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      do_fetch(32'h0800_0010);
      do_retire(1'b1, 1'b0, 1'b0);
      total++; if (Imem_Addr !== 32'h40) begin bad++; $display("FAIL ri_addr40: got %h want 00000040", Imem_Addr); end
      do_fetch(32'h2108_0001);
      total++; if (Instr_Valid !== 1'b1 || PC !== 32'h40) begin bad++; $display("FAIL ri_issue: got iv=%b pc=%h want iv=1 pc=00000040", Instr_Valid, PC); end
      RST = 1'b1;
      tick();
      total++; if (Instr_Valid !== 1'b0) begin bad++; $display("FAIL ri_ivalid: got %b want 0", Instr_Valid); end
      total++; if (PC !== 32'h0) begin bad++; $display("FAIL ri_pc: got %h want 00000000", PC); end
      total++; if (Retire_Count !== 32'd0) begin bad++; $display("FAIL ri_count: got %0d want 0", Retire_Count); end
      total++; if (Imem_Req !== 1'b0) begin bad++; $display("FAIL ri_req: got %b want 0", Imem_Req); end
      RST = 1'b0;
      #1;
      total++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h0) begin bad++; $display("FAIL ri_refetch: got req=%b addr=%h want req=1 addr=00000000", Imem_Req, Imem_Addr); end
   endtask

   task automatic test_wrap();
      do_fetch(32'h1000_FFFE);
      do_retire(1'b0, 1'b1, 1'b1);
      total++; if (Imem_Addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_back: got %h want fffffffc", Imem_Addr); end
      do_fetch(32'h0000_0000);
      total++; if (PC_Plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4: got %h want 00000000", PC_Plus4); end
      do_retire(1'b0, 1'b0, 1'b0);
      total++; if (Imem_Addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 00000000", Imem_Addr); end
      total++; if (Retire_Count !== 32'd2) begin bad++; $display("FAIL wrap_count: got %0d want 2", Retire_Count); end
   endtask

   task automatic test_back_to_back();
      // Zero-wait memory: a new request every second cycle.
      for (int i = 0; i < 3; i++) begin
         total++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'(4 * i)) begin bad++; $display("FAIL b2b_req%0d: got req=%b addr=%h want req=1 addr=%h", i, Imem_Req, Imem_Addr, 32'(4 * i)); end
         do_fetch(32'hAC01_0000);
         do_retire(1'b0, 1'b0, 1'b0);
      end
      total++; if (Retire_Count !== 32'd5) begin bad++; $display("FAIL b2b_count: got %0d want 5", Retire_Count); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_delayed_valid();
      test_branch();
      test_stall();
      test_jump();
      test_reset_in_issue();
      test_wrap();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction and PC width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 Jump  in  1  from control unit: current instruction is J.
REQ-006 Branch  in  1  from control unit: current instruction is BEQ.
REQ-007 Zero  in  1  from ALU: branch comparison equal.
REQ-008 Stall  in  1  downstream hold: keep current instruction presented.
REQ-009 Imem_Req  out  1  instruction-memory read request.
REQ-010 Imem_Addr  out  DATA_WIDTH  byte address of request (= PC).
REQ-011 Imem_Rdata  in  DATA_WIDTH  returned instruction word.
REQ-012 Imem_Valid  in  1  Imem_Rdata valid this cycle.
REQ-013 Instr  out  DATA_WIDTH  registered current instruction.
REQ-014 Instr_Valid  out  1  Instr is live and may be executed.
REQ-015 Op_Code  out  6  Instr[31:26], feeds control unit.
REQ-016 PC  out  DATA_WIDTH  address of Instr.
REQ-017 PC_Plus4  out  DATA_WIDTH  PC + 4, modulo 2^32.
REQ-018 Retire_Count  out  32  count of retired instructions.

Function
REQ-019 FSM shall have two states: FETCH and ISSUE.
REQ-020 In FETCH, Imem_Req shall be 1 and Imem_Addr = PC, held stable until Imem_Valid is sampled 1.
REQ-021 FETCH with Imem_Valid=1 (including the first Req cycle) shall capture Imem_Rdata into Instr and go to ISSUE, with Instr_Valid=1 from the next cycle.
REQ-022 Imem_Valid shall be ignored outside FETCH.
REQ-023 In ISSUE, Imem_Req=0; the instruction retires on the first cycle with Stall=0.
REQ-024 At retire: PC <= next PC, Instr_Valid <= 0, Retire_Count += 1 (wraps at 2^32), state <= FETCH.
REQ-025 In ISSUE with Stall=1, Instr, PC, Instr_Valid, Retire_Count shall hold.
REQ-026 Next PC, priority order: Jump=1 -> {PC_Plus4[31:28], Instr[25:0], 2'b00}; Branch=1 and Zero=1 -> PC_Plus4 + (sign-extended Instr[15:0] << 2); else PC_Plus4.
REQ-027 Jump, Branch, Zero shall be sampled only at the retire cycle; other cycles they are don't-care.
REQ-028 All address arithmetic shall be modulo 2^32; PC 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 Op_Code shall be Instr[31:26] combinationally, regardless of Instr_Valid; downstream gates execution with Instr_Valid.
REQ-030 Minimum throughput: one instruction per 2 cycles (zero-wait memory, no stall).

Reset
REQ-031 While RST=1 at a clock edge: PC <= RESET_PC, Instr <= 0 (NOP), Instr_Valid <= 0, Retire_Count <= 0, state <= FETCH.
REQ-032 Imem_Req shall be 0 in any cycle with RST=1; the first request issues in the first cycle after RST deasserts.
REQ-033 RST asserted mid-FETCH or mid-ISSUE shall abandon the pending request/instruction without retiring it; memory is reset by the same RST.

Structure
REQ-034 Shared package: FSM state encoding, opcode constants (OP_RTYPE 000000, OP_J 000010, OP_BEQ 000100, OP_ADDI 001000, OP_LW 100011, OP_SW 101011), default RESET_PC.
REQ-035 One combinational sub-module, next_pc_calc, shall implement REQ-026 and PC_Plus4.

Verification
REQ-036 Reset, zero-wait memory returning 32'h2008_0005 at 0 -> Imem_Req 1 cycle after RST drops, Op_Code=001000, PC=0, then Imem_Addr=4.
REQ-037 Imem_Valid delayed 3 cycles -> Imem_Req/Imem_Addr stable for 4 cycles, Instr_Valid rises once.
REQ-038 At PC=8, Instr=32'h1000_FFFE, Branch=1, Zero=1 -> next Imem_Addr=32'h0000_0004; Zero=0 -> 32'h0000_000C.
REQ-039 At PC=32'h1000_0000, Instr=32'h0800_0040, Jump=1, Branch=1, Zero=1 -> next Imem_Addr=32'h1000_0100 (jump wins).
REQ-040 Stall held 5 cycles in ISSUE -> Instr/PC constant, Retire_Count unchanged, no Imem_Req; increments by 1 after release.
REQ-041 RST pulsed during ISSUE at PC=32'h40 -> Instr_Valid=0, PC=RESET_PC, Retire_Count=0 next cycle.
